mem_access: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM pipeline bundle produced by the execute stage and drives the data-memory request/acknowledge bus.
- Performs load extraction (word/byte/half, signed/unsigned) and selects the writeback value.
- Registers the MEM/WB bundle, returns MEM-stage forwarding data to execute, and stalls upstream stages while a memory access is outstanding.

---
 rtl/mem_access.sv | 197 +++++++++++++++++++
 tb/tb_mem_access.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : memory-access stage of the 5-stage MIPS pipeline.
//
// Takes the EX/MEM bundle and drives the data-memory request/acknowledge bus.
// It extracts load data (LW / LB / LBU / LH) and selects the writeback value,
// which it registers into the MEM/WB bundle. It also returns MEM-stage
// forwarding data to execute. While a memory access is still outstanding it
// stalls the upstream stages. An access that gets no acknowledge within
// TIMEOUT cycles is completed anyway: load data reads as zero and o_err is set.
//
// Ports
//   i_clk, i_nrst        clock, synchronous active-low reset
//   i_data_* / i_addr_*  EX/MEM datapath bundle (PC+4, ALU result, store data,
//                        destination register)
//   i_con_*              EX/MEM control bundle (load/store, load type,
//                        PC+8 select, mem-to-reg, register write)
//   o_mem_* / i_mem_*    data-memory bus (req/we/be/addr/wdata, ack/rdata)
//   o_stall              freeze IF/ID/EX and EX/MEM while the access is pending
//   o_*FM*               MEM-stage forwarding value, destination and enable
//   o_data_wbres,
//   o_addr_regdst,
//   o_con_Wregwrite      registered MEM/WB bundle
//   o_err                sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [31:0] i_data_pc4,
  input  logic [31:0] i_data_alures,
  input  logic [31:0] i_data_rt,
  input  logic [4:0]  i_addr_regdst,
  input  logic        i_con_Mmemread,
  input  logic        i_con_Mmemwrite,
  input  logic [1:0]  i_con_Wloadmux,
  input  logic        i_con_Walupc8,
  input  logic        i_con_Wmemtoreg,
  input  logic        i_con_Wregwrite,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic [31:0] o_data_FMalures,
  output logic [4:0]  o_addr_FMregdst,
  output logic        o_con_FMregwrite,
  output logic [31:0] o_data_wbres,
  output logic [4:0]  o_addr_regdst,
  output logic        o_con_Wregwrite,
  output logic        o_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      wbres_q, wbres_d;
  logic [4:0]       regdst_q, regdst_d;
  logic             regwrite_q, regwrite_d;

  logic        acc;
  logic        timeout;
  logic        done;
  logic        stall;
  logic [31:0] alu_or_link;
  logic [31:0] rdata_eff;
  logic [7:0]  lane_byte;
  logic [15:0] half_word;
  logic [31:0] load_data;

  // ---------------------------------------------------------------------------
  // Access handshake
  // ---------------------------------------------------------------------------
  assign acc = i_con_Mmemread | i_con_Mmemwrite;

  // Timeout fires on the last permitted wait cycle. A late ack in that same
  // cycle still wins, and the access then completes normally.
  assign timeout = (state_q == BUSY) & ~i_mem_ack & (cnt_q == CNT_LAST);
  assign done    = acc & (i_mem_ack | timeout);

  // During reset the bus and the stall are forced quiet, so an abandoned
  // access does not hold the pipeline.
  assign stall   = acc & ~done & i_nrst;
  assign o_stall = stall;

  // ---------------------------------------------------------------------------
  // Memory bus
  // ---------------------------------------------------------------------------
  assign o_mem_req   = acc & i_nrst;
  assign o_mem_we    = i_con_Mmemwrite;
  assign o_mem_be    = i_con_Mmemwrite ? 4'b1111 : 4'b0000;
  assign o_mem_addr  = {i_data_alures[31:2], 2'b00};
  assign o_mem_wdata = i_data_rt;

  // ---------------------------------------------------------------------------
  // Load extraction and writeback select
  // ---------------------------------------------------------------------------
  assign rdata_eff   = timeout ? 32'd0 : i_mem_rdata;
  assign lane_byte   = rdata_eff[{i_data_alures[1:0], 3'b000} +: 8];
  assign half_word   = i_data_alures[1] ? rdata_eff[31:16] : rdata_eff[15:0];
  assign alu_or_link = i_con_Walupc8 ? (i_data_pc4 + 32'd4) : i_data_alures;

  always_comb begin
    load_data = rdata_eff;
    case (i_con_Wloadmux)
      2'b00:   load_data = rdata_eff;
      2'b01:   load_data = {{24{lane_byte[7]}}, lane_byte};
      2'b10:   load_data = {24'd0, lane_byte};
      default: load_data = {{16{half_word[15]}}, half_word};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding: load data only exists late in the cycle, so a load is never
  // forwarded from MEM. Execute must take it from WB instead.
  // ---------------------------------------------------------------------------
  assign o_data_FMalures  = alu_or_link;
  assign o_addr_FMregdst  = i_addr_regdst;
  assign o_con_FMregwrite = i_con_Wregwrite & ~i_con_Wmemtoreg;

  // ---------------------------------------------------------------------------
  // Wait-state FSM and sticky error
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (acc & ~i_mem_ack) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register: a stalled cycle inserts a bubble and keeps data/address
  // ---------------------------------------------------------------------------
  always_comb begin
    wbres_d    = wbres_q;
    regdst_d   = regdst_q;
    regwrite_d = 1'b0;
    if (!stall) begin
      wbres_d    = i_con_Wmemtoreg ? load_data : alu_or_link;
      regdst_d   = i_addr_regdst;
      regwrite_d = i_con_Wregwrite;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      wbres_q    <= 32'd0;
      regdst_q   <= 5'd0;
      regwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      wbres_q    <= wbres_d;
      regdst_q   <= regdst_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign o_data_wbres    = wbres_q;
  assign o_addr_regdst   = regdst_q;
  assign o_con_Wregwrite = regwrite_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access : scoreboard bench for mem_access.
// The driver issues one instruction at a time, acknowledging after a chosen
// number of wait cycles. It pushes the expected MEM/WB record and checks the
// per-cycle combinational outputs. A separate monitor pops the scoreboard
// each time the DUT captures into MEM/WB. It also checks bubbles during stalls
// and zeros after reset.
// -----------------------------------------------------------------------------
module tb_mem_access;

  localparam int TIMEOUT = 16;

  logic        i_clk;
  logic        i_nrst;
  logic [31:0] i_data_pc4, i_data_alures, i_data_rt;
  logic [4:0]  i_addr_regdst;
  logic        i_con_Mmemread, i_con_Mmemwrite;
  logic [1:0]  i_con_Wloadmux;
  logic        i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite;
  logic        o_mem_req, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_stall;
  logic [31:0] o_data_FMalures;
  logic [4:0]  o_addr_FMregdst;
  logic        o_con_FMregwrite;
  logic [31:0] o_data_wbres;
  logic [4:0]  o_addr_regdst;
  logic        o_con_Wregwrite;
  logic        o_err;

  mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_data_pc4(i_data_pc4), .i_data_alures(i_data_alures), .i_data_rt(i_data_rt),
    .i_addr_regdst(i_addr_regdst),
    .i_con_Mmemread(i_con_Mmemread), .i_con_Mmemwrite(i_con_Mmemwrite),
    .i_con_Wloadmux(i_con_Wloadmux), .i_con_Walupc8(i_con_Walupc8),
    .i_con_Wmemtoreg(i_con_Wmemtoreg), .i_con_Wregwrite(i_con_Wregwrite),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_stall(o_stall),
    .o_data_FMalures(o_data_FMalures), .o_addr_FMregdst(o_addr_FMregdst),
    .o_con_FMregwrite(o_con_FMregwrite),
    .o_data_wbres(o_data_wbres), .o_addr_regdst(o_addr_regdst),
    .o_con_Wregwrite(o_con_Wregwrite), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_exp  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference load extraction, written from the load-type rules directly.
  function automatic logic [31:0] load_val(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((d >> (8 * int'(a[1:0]))) & 32'hFF);
    h = a[1] ? d[31:16] : d[15:0];
    case (m)
      2'd0:    return d;
      2'd1:    return 32'($signed(b));
      2'd2:    return {24'd0, b};
      default: return 32'($signed(h));
    endcase
  endfunction

  // ack_at: cycle index (0 = first cycle) at which ack is given, -1 = never.
  // abort_at: leave the instruction after that many cycles, no WB expected.
  task automatic issue(input logic [31:0] pc4, input logic [31:0] alures,
                       input logic [31:0] rt, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic [1:0] lm,
                       input logic pc8, input logic m2r, input logic rw,
                       input logic [31:0] rdata, input int ack_at, input int abort_at);
    logic        acc, timed_out, done, stall_e;
    logic [31:0] fwd;
    exp_t        e;
    int          c;
    acc       = mr | mw;
    fwd       = pc8 ? pc4 + 32'd4 : alures;
    timed_out = acc && (ack_at < 0 || ack_at > TIMEOUT);
    e.wb = m2r ? load_val(timed_out ? 32'd0 : rdata, alures, lm) : fwd;
    e.rd = rd;
    e.rw = rw;
    if (abort_at < 0) sb.push_back(e);
    i_data_pc4 = pc4; i_data_alures = alures; i_data_rt = rt; i_addr_regdst = rd;
    i_con_Mmemread = mr; i_con_Mmemwrite = mw; i_con_Wloadmux = lm;
    i_con_Walupc8 = pc8; i_con_Wmemtoreg = m2r; i_con_Wregwrite = rw;
    c = 0;
    forever begin
      i_mem_ack   = (c == ack_at);
      i_mem_rdata = (c == ack_at) ? rdata : $urandom;
      done    = acc && ((c == ack_at) || (timed_out && c == TIMEOUT));
      stall_e = acc && !done;
      @(negedge i_clk);
      chk("stall", {31'd0, o_stall}, {31'd0, stall_e});
      chk("mem_req", {31'd0, o_mem_req}, {31'd0, acc});
      chk("err", {31'd0, o_err}, {31'd0, err_exp});
      chk("fm_alures", o_data_FMalures, fwd);
      chk("fm_regdst", {27'd0, o_addr_FMregdst}, {27'd0, rd});
      chk("fm_regwrite", {31'd0, o_con_FMregwrite}, {31'd0, rw & ~m2r});
      if (acc) begin
        chk("mem_we", {31'd0, o_mem_we}, {31'd0, mw});
        chk("mem_be", {28'd0, o_mem_be}, mw ? 32'hF : 32'h0);
        chk("mem_addr", o_mem_addr, alures & 32'hFFFF_FFFC);
        chk("mem_wdata", o_mem_wdata, rt);
      end
      @(posedge i_clk);
      #1;
      if (done && timed_out) err_exp = 1'b1;
      if (!stall_e) break;
      c++;
      if (c == abort_at) break;
      if (c > 60) begin
        n_checks++; n_fail++;
        $display("FAIL stall_bound: got stall after %0d cycles expected completion", c);
        break;
      end
    end
    i_mem_ack = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_nrst = 1'b0;
    i_con_Mmemread = 1'b1;
    i_con_Mmemwrite = 1'b0;
    i_mem_ack = 1'b0;
    repeat (n) begin
      @(negedge i_clk);
      chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      @(posedge i_clk);
      #1;
    end
    err_exp = 1'b0;
    i_nrst = 1'b1;
    i_con_Mmemread = 1'b0;
  endtask

  // Monitor: kind of the previous cycle decides what the WB outputs must show.
  int          prev_kind = 0;  // 0 none, 1 reset, 2 stall, 3 capture
  logic [31:0] last_wb;
  logic [4:0]  last_rd;
  always @(negedge i_clk) begin
    exp_t e;
    case (prev_kind)
      1: begin
        chk("rst_wbres", o_data_wbres, 32'd0);
        chk("rst_regdst", {27'd0, o_addr_regdst}, 32'd0);
        chk("rst_wregwrite", {31'd0, o_con_Wregwrite}, 32'd0);
      end
      2: begin
        chk("bubble_wregwrite", {31'd0, o_con_Wregwrite}, 32'd0);
        chk("hold_wbres", o_data_wbres, last_wb);
        chk("hold_regdst", {27'd0, o_addr_regdst}, {27'd0, last_rd});
      end
      3: begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wb_unexpected: got wb=%h with empty scoreboard", o_data_wbres);
        end else begin
          e = sb.pop_front();
          chk("wb_wbres", o_data_wbres, e.wb);
          chk("wb_regdst", {27'd0, o_addr_regdst}, {27'd0, e.rd});
          chk("wb_wregwrite", {31'd0, o_con_Wregwrite}, {31'd0, e.rw});
          $display("WB wbres=%h regdst=%0d regwrite=%0b", o_data_wbres, o_addr_regdst,
                   o_con_Wregwrite);
        end
      end
      default: ;
    endcase
    last_wb = o_data_wbres;
    last_rd = o_addr_regdst;
    prev_kind = !i_nrst ? 1 : (o_stall ? 2 : 3);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pick, ack_at, kind;
    logic [31:0] a;
    logic        mr, mw;
    i_nrst = 1'b0; i_data_pc4 = 0; i_data_alures = 0; i_data_rt = 0; i_addr_regdst = 0;
    i_con_Mmemread = 1'b1; i_con_Mmemwrite = 0; i_con_Wloadmux = 0; i_con_Walupc8 = 0;
    i_con_Wmemtoreg = 0; i_con_Wregwrite = 0; i_mem_ack = 0; i_mem_rdata = 0;
    @(posedge i_clk); #1;
    do_reset(2);

    // Directed cases
    issue(32'h0, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 2'd0, 0, 0, 1, 32'h0, 0, -1);
    issue(32'h0, 32'h0000_0103, 32'h0, 5'd6, 1, 0, 2'd1, 0, 1, 1, 32'h80FF_FF7F, 0, -1);
    issue(32'h0, 32'h0000_0103, 32'h0, 5'd7, 1, 0, 2'd2, 0, 1, 1, 32'h80FF_FF7F, 0, -1);
    issue(32'h0, 32'h0000_0102, 32'h0, 5'd8, 1, 0, 2'd3, 0, 1, 1, 32'h80FF_FF7F, 0, -1);
    issue(32'h0, 32'h0000_0200, 32'h0, 5'd9, 1, 0, 2'd0, 0, 1, 1, 32'hCAFE_F00D, 3, -1);
    issue(32'h400, 32'h0000_0077, 32'h0, 5'd31, 0, 0, 2'd0, 1, 0, 1, 32'h0, 0, -1);
    issue(32'h0, 32'h0000_0300, 32'hA5A5_A5A5, 5'd0, 0, 1, 2'd0, 0, 0, 0, 32'h0, 1, -1);
    issue(32'h0, 32'h0000_0304, 32'h1111_2222, 5'd0, 1, 1, 2'd0, 0, 0, 0, 32'h0, 0, -1);
    // Ack on the very last permitted cycle still counts as a normal completion
    issue(32'h0, 32'h0000_0400, 32'h0, 5'd10, 1, 0, 2'd0, 0, 1, 1, 32'h1357_9BDF, TIMEOUT, -1);
    // Timeout: load data reads as zero, error becomes sticky
    issue(32'h0, 32'h0000_0500, 32'h0, 5'd11, 1, 0, 2'd0, 0, 1, 1, 32'hFFFF_FFFF, -1, -1);
    issue(32'h0, 32'h0000_0010, 32'h0, 5'd12, 0, 0, 2'd0, 0, 0, 1, 32'h0, 0, -1);
    // Reset in the middle of a wait, then a full fresh timeout
    issue(32'h0, 32'h0000_0600, 32'h0, 5'd13, 1, 0, 2'd0, 0, 1, 1, 32'h0, -1, 5);
    do_reset(1);
    issue(32'h0, 32'h0000_0020, 32'h0, 5'd14, 0, 0, 2'd0, 0, 0, 1, 32'h0, 0, -1);
    issue(32'h0, 32'h0000_0601, 32'h0, 5'd15, 1, 0, 2'd1, 0, 1, 1, 32'h0, -1, -1);

    // Randomized instruction mix
    for (int i = 0; i < 150; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2, 3: ack_at = 0;
        4: ack_at = 1;
        5: ack_at = 2;
        6: ack_at = 3;
        7: ack_at = 5;
        8: ack_at = TIMEOUT - 1;
        default: ack_at = ($urandom_range(0, 3) == 0) ? -1 : 7;
      endcase
      kind = $urandom_range(0, 5);
      a = $urandom;
      case (kind)
        0, 1: issue($urandom, a, $urandom, 5'($urandom), 0, 0, 2'($urandom), 0, 0,
                    1'($urandom), $urandom, ack_at, -1);
        2:    issue($urandom, a, $urandom, 5'($urandom), 0, 0, 2'($urandom), 1, 0,
                    1, $urandom, ack_at, -1);
        3, 4: issue($urandom, a, $urandom, 5'($urandom), 1, 0, 2'($urandom), 0, 1,
                    1'($urandom), $urandom, ack_at, -1);
        default: begin
          mr = 1'($urandom_range(0, 1));
          mw = 1'b1;
          issue($urandom, a, $urandom, 5'($urandom), mr, mw, 2'($urandom), 0, 0,
                0, $urandom, ack_at, -1);
        end
      endcase
    end

    do_reset(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
